// File: rtl/logic_ops_pkg.sv
// ============================================================================
// Module   : logic_ops_pkg
// Brief    : Opcode encodings and per-bit evaluator for the shared logic unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package logic_ops_pkg;

    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] OP_NOT = 2'b00;
    localparam logic [OP_W-1:0] OP_AND = 2'b01;
    localparam logic [OP_W-1:0] OP_OR  = 2'b10;
    localparam logic [OP_W-1:0] OP_XOR = 2'b11;

    function automatic logic op_bit(input logic [OP_W-1:0] op,
                                    input logic a,
                                    input logic b);
        logic r;
        case (op)
            OP_NOT:  r = ~a;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick starting at ptr; gated by en.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    input  logic                    en,
    output logic [NREQ-1:0]         gnt
);

    localparam int c_IW = $clog2(NREQ);
    localparam int c_SW = c_IW + 1;

    logic [NREQ-1:0] w_gnt;
    logic            w_found;
    logic [c_SW-1:0] w_sum;
    logic [c_IW-1:0] w_idx;

    // Walk ptr, ptr+1, ... with wrap at NREQ (NREQ need not be a power of two).
    always_comb begin
        w_gnt   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sum = {1'b0, ptr} + c_SW'(i);
            w_idx = c_IW'((w_sum >= c_SW'(NREQ)) ? (w_sum - c_SW'(NREQ)) : w_sum);
            if (en && !w_found && req[w_idx]) begin
                w_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

    assign gnt = w_gnt;

endmodule

`default_nettype wire

// File: rtl/logic_unit_arbiter.sv
// ============================================================================
// Module   : logic_unit_arbiter
// Brief    : Round-robin shared bitwise logic unit with registered result and
//            valid/ready output handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module logic_unit_arbiter
    import logic_ops_pkg::*;
#(
    parameter int N    = 5,
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*N-1:0]       op_a,
    input  logic [NREQ*N-1:0]       op_b,
    input  logic [NREQ*OP_W-1:0]    op_sel,
    output logic [NREQ-1:0]         gnt,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [N-1:0]            res_data,
    output logic [$clog2(NREQ)-1:0] res_id,
    output logic [15:0]             op_count
);

    localparam int c_IW = $clog2(NREQ);

    logic            r_valid;
    logic [N-1:0]    r_data;
    logic [c_IW-1:0] r_id;
    logic [c_IW-1:0] r_ptr;
    logic [15:0]     r_count;

    logic            w_accept;
    logic [NREQ-1:0] w_gnt;
    logic [c_IW-1:0] w_idx;
    logic [c_IW-1:0] w_ptr_nxt;
    logic [N-1:0]    w_a;
    logic [N-1:0]    w_b;
    logic [OP_W-1:0] w_op;
    logic [N-1:0]    w_res;

    // rst_n in the accept term keeps gnt low for the whole reset interval.
    assign w_accept = rst_n && (|req) && (!r_valid || res_ready);

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req (req),
        .ptr (r_ptr),
        .en  (w_accept),
        .gnt (w_gnt)
    );

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_idx = w_idx | c_IW'(i);
            end
        end
    end

    assign w_a       = op_a[int'(w_idx)*N +: N];
    assign w_b       = op_b[int'(w_idx)*N +: N];
    assign w_op      = op_sel[int'(w_idx)*OP_W +: OP_W];
    assign w_ptr_nxt = (w_idx == c_IW'(NREQ-1)) ? '0 : (w_idx + c_IW'(1));

    for (genvar b = 0; b < N; b++) begin : g_bit
        assign w_res[b] = op_bit(w_op, w_a[b], w_b[b]);
    end

    // Accept overwrites even while consuming, so back-to-back results have no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_id    <= '0;
            r_ptr   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= w_res;
            r_id    <= w_idx;
            r_ptr   <= w_ptr_nxt;
            r_count <= r_count + 16'd1;
        end else if (r_valid && res_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign gnt       = w_gnt;
    assign res_valid = r_valid;
    assign res_data  = r_data;
    assign res_id    = r_id;
    assign op_count  = r_count;

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
// ============================================================================
// Module   : tb_logic_unit_arbiter
// Brief    : Vector table plus scoreboard bench for logic_unit_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_logic_unit_arbiter;

    localparam int c_N    = 5;
    localparam int c_NREQ = 4;

    logic                  clk;
    logic                  rst_n;
    logic [c_NREQ-1:0]     req;
    logic [c_NREQ*c_N-1:0] op_a;
    logic [c_NREQ*c_N-1:0] op_b;
    logic [c_NREQ*2-1:0]   op_sel;
    logic [c_NREQ-1:0]     gnt;
    logic                  res_valid;
    logic                  res_ready;
    logic [c_N-1:0]        res_data;
    logic [1:0]            res_id;
    logic [15:0]           op_count;

    logic_unit_arbiter #(
        .N    (c_N),
        .NREQ (c_NREQ)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sel    (op_sel),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] c_NOT = 2'b00;
    localparam logic [1:0] c_AND = 2'b01;
    localparam logic [1:0] c_OR  = 2'b10;
    localparam logic [1:0] c_XOR = 2'b11;

    typedef struct {
        string      name;
        logic [3:0] req;
        logic [4:0] a;
        logic [4:0] b;
        logic [1:0] sel;
        logic       ready;
        logic [3:0] exp_gnt;
        logic [4:0] exp_data;
    } vec_t;

    typedef struct {
        logic [4:0] data;
        logic [1:0] id;
    } sb_t;

    sb_t         sb[$];
    logic [15:0] m_count;
    int          pass_cnt;
    int          tot_cnt;
    vec_t        vecs[22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [1:0] enc(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic check_out(input string nm);
        chk({nm, " res_valid"}, 32'(res_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk({nm, " res_data"}, 32'(res_data), 32'(sb[0].data));
            chk({nm, " res_id"}, 32'(res_id), 32'(sb[0].id));
        end
        chk({nm, " op_count"}, 32'(op_count), 32'(m_count));
    endtask

    // Called at posedge+1; checks gnt mid-cycle, then outputs after the edge.
    task automatic apply(input string nm, input logic [3:0] rq, input logic [4:0] a,
                         input logic [4:0] b, input logic [1:0] sel, input logic rdy,
                         input logic [3:0] eg, input logic [4:0] ed);
        sb_t e;
        req       = rq;
        op_a      = {4{a}};
        op_b      = {4{b}};
        op_sel    = {4{sel}};
        res_ready = rdy;
        #4;
        chk({nm, " gnt"}, 32'(gnt), 32'(eg));
        if (rdy && sb.size() != 0) sb.delete(0);
        if (eg != 4'b0000) begin
            e.data = ed;
            e.id   = enc(eg);
            sb.push_back(e);
            m_count = m_count + 16'd1;
        end
        @(posedge clk);
        #1;
        check_out(nm);
    endtask

    initial begin
        pass_cnt  = 0;
        tot_cnt   = 0;
        m_count   = 16'd0;
        rst_n     = 1'b0;
        req       = 4'b1111;
        op_a      = '0;
        op_b      = '0;
        op_sel    = '0;
        res_ready = 1'b1;

        vecs[0]  = '{"single_not", 4'b0010, 5'b10110, 5'b00000, c_NOT, 1'b1, 4'b0010, 5'b01001};
        vecs[1]  = '{"op_and",     4'b0001, 5'b11001, 5'b10101, c_AND, 1'b1, 4'b0001, 5'b10001};
        vecs[2]  = '{"op_or",      4'b0001, 5'b11001, 5'b10101, c_OR,  1'b1, 4'b0001, 5'b11101};
        vecs[3]  = '{"op_xor",     4'b0001, 5'b11001, 5'b10101, c_XOR, 1'b1, 4'b0001, 5'b01100};
        vecs[4]  = '{"op_not",     4'b0001, 5'b11001, 5'b10101, c_NOT, 1'b1, 4'b0001, 5'b00110};
        vecs[5]  = '{"idle",       4'b0000, 5'b00000, 5'b00000, c_NOT, 1'b1, 4'b0000, 5'b00000};
        vecs[6]  = '{"req3",       4'b1000, 5'b00000, 5'b00000, c_XOR, 1'b1, 4'b1000, 5'b00000};
        for (int i = 0; i < 8; i++)
            vecs[7+i] = '{"fair", 4'b1111, 5'b00001, 5'b00010, c_OR, 1'b1,
                          4'(1 << (i % 4)), 5'b00011};
        for (int i = 0; i < 3; i++)
            vecs[15+i] = '{"stall", 4'b0100, 5'b11111, 5'b00000, c_NOT, 1'b0, 4'b0000, 5'b00000};
        vecs[18] = '{"unstall",    4'b0100, 5'b11111, 5'b00000, c_NOT, 1'b1, 4'b0100, 5'b00000};
        vecs[19] = '{"rr_skip0",   4'b0101, 5'b11100, 5'b00111, c_AND, 1'b1, 4'b0001, 5'b00100};
        vecs[20] = '{"rr_skip1",   4'b0101, 5'b10000, 5'b00001, c_OR,  1'b1, 4'b0100, 5'b10001};
        vecs[21] = '{"rr_skip2",   4'b0101, 5'b11111, 5'b10101, c_XOR, 1'b1, 4'b0001, 5'b01010};

        #2;
        chk("reset gnt", 32'(gnt), 32'h0);
        chk("reset res_valid", 32'(res_valid), 32'h0);
        chk("reset res_data", 32'(res_data), 32'h0);
        chk("reset res_id", 32'(res_id), 32'h0);
        chk("reset op_count", 32'(op_count), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req   = 4'b0000;

        foreach (vecs[i])
            apply(vecs[i].name, vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].sel,
                  vecs[i].ready, vecs[i].exp_gnt, vecs[i].exp_data);

        // Asynchronous reset while the output stage is stalled.
        apply("pre_rst", 4'b0010, 5'b00000, 5'b00000, c_NOT, 1'b1, 4'b0010, 5'b11111);
        apply("rst_stall", 4'b0010, 5'b00000, 5'b00000, c_NOT, 1'b0, 4'b0000, 5'b00000);
        #2;
        rst_n     = 1'b0;
        res_ready = 1'b1;
        #1;
        chk("async_rst gnt", 32'(gnt), 32'h0);
        chk("async_rst res_valid", 32'(res_valid), 32'h0);
        chk("async_rst res_data", 32'(res_data), 32'h0);
        chk("async_rst op_count", 32'(op_count), 32'h0);
        sb.delete();
        m_count = 16'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply("post_rst_ptr", 4'b1010, 5'b00001, 5'b00000, c_NOT, 1'b1, 4'b0010, 5'b11110);
        apply("post_rst_req3", 4'b1000, 5'b11111, 5'b01010, c_AND, 1'b1, 4'b1000, 5'b01010);

        // Counter wrap: stream accepts from requester 0 up to 16'hFFFF.
        req       = 4'b0001;
        op_a      = '0;
        op_b      = '0;
        op_sel    = {4{c_NOT}};
        res_ready = 1'b1;
        repeat (65533) @(posedge clk);
        #1;
        sb.delete();
        sb.push_back('{data: 5'b11111, id: 2'd0});
        m_count = 16'hFFFF;
        check_out("preload");
        apply("wrap", 4'b0001, 5'b01010, 5'b00000, c_NOT, 1'b1, 4'b0001, 5'b10101);
        chk("wrap zero", 32'(op_count), 32'h0);
        apply("drain", 4'b0000, 5'b00000, 5'b00000, c_NOT, 1'b1, 4'b0000, 5'b00000);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

`default_nettype wire
